// File: rtl/clock_gate_pkg.sv
// Shared types and helpers for the per-peripheral clock-request controller.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'd0,
    CG_WAKE = 2'd1,
    CG_ON   = 2'd2
  } cg_state_t;

  localparam int STATS_W = 16;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cg_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clock_gate_chan.sv
// One clock-request channel: OFF/WAKE/ON FSM with wake and idle counters.
// Optional gated-cycle statistics counter under CLK_GATE_STATS_EN.
module clock_gate_chan
  import clock_gate_pkg::*;
#(
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               scan_en,
  input  logic               act,
`ifdef CLK_GATE_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] gated_cnt,
`endif
  output logic               req_o,
  output logic               ack_o,
  output cg_state_t          state_o
);

  localparam int WAKE_W = cg_cnt_w(WAKE_CYC);
  localparam int IDLE_W = cg_cnt_w(IDLE_CYC);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

  cg_state_t         state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    req_d      = req_q;
    ack_d      = ack_q;
    // Scan mode freezes the channel; the top forces the outputs high.
    if (!scan_en) begin
      unique case (state_q)
        CG_OFF: begin
          if (act) begin
            state_d    = CG_WAKE;
            wake_cnt_d = '0;
            req_d      = 1'b1;
          end
        end
        CG_WAKE: begin
          if (wake_cnt_q == WAKE_LAST) begin
            state_d    = CG_ON;
            idle_cnt_d = '0;
            ack_d      = 1'b1;
          end else begin
            wake_cnt_d = wake_cnt_q + 1'b1;
          end
        end
        CG_ON: begin
          if (act) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d    = CG_OFF;
            idle_cnt_d = '0;
            req_d      = 1'b0;
            ack_d      = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = CG_OFF;
          req_d   = 1'b0;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CG_OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
    end
  end

  assign req_o   = req_q;
  assign ack_o   = ack_q;
  assign state_o = state_q;

`ifdef CLK_GATE_STATS_EN
  logic [STATS_W-1:0] stats_q, stats_d;

  // Clear wins over increment; the count sticks at all-ones.
  always_comb begin
    stats_d = stats_q;
    if (stats_clr) begin
      stats_d = '0;
    end else if (!scan_en && (state_q == CG_OFF) && (stats_q != '1)) begin
      stats_d = stats_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign gated_cnt = stats_q;
`endif

endmodule

// File: rtl/clock_gate_ctrl.sv
// N independent clock-request channels plus scan override and all_idle decode.
// Define CLK_GATE_STATS_EN to add stats_clr and per-channel gated_cnt counters.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 scan_en,
  input  logic [N-1:0]         wake_req,
  input  logic [N-1:0]         busy,
  input  logic [N-1:0]         force_on,
`ifdef CLK_GATE_STATS_EN
  input  logic                 stats_clr,
  output logic [N*STATS_W-1:0] gated_cnt,
`endif
  output logic [N-1:0]         clk_req,
  output logic [N-1:0]         clk_ack,
  output logic                 all_idle
);

  logic [N-1:0] req_vec;
  logic [N-1:0] ack_vec;
  logic [N-1:0] off_vec;

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic      act;
    cg_state_t st;

    assign act = wake_req[i] | busy[i] | force_on[i];

    clock_gate_chan #(
      .IDLE_CYC (IDLE_CYC),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .scan_en   (scan_en),
      .act       (act),
`ifdef CLK_GATE_STATS_EN
      .stats_clr (stats_clr),
      .gated_cnt (gated_cnt[i*STATS_W +: STATS_W]),
`endif
      .req_o     (req_vec[i]),
      .ack_o     (ack_vec[i]),
      .state_o   (st)
    );

    assign off_vec[i] = (st == CG_OFF);
  end

  // Combinational scan bypass: outputs return to registered values the moment scan_en drops.
  assign clk_req  = scan_en ? {N{1'b1}} : req_vec;
  assign clk_ack  = scan_en ? {N{1'b1}} : ack_vec;
  assign all_idle = &off_vec;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: vector table, corner sequences, random vs. model.
module tb_clock_gate_ctrl;

  localparam int N        = 4;
  localparam int IDLE_CYC = 16;
  localparam int WAKE_CYC = 2;
  localparam int OW       = 2 * N + 1;

  logic         clk_in   = 1'b0;
  logic         rst_n    = 1'b0;
  logic         scan_en  = 1'b0;
  logic [N-1:0] wake_req = '0;
  logic [N-1:0] busy     = '0;
  logic [N-1:0] force_on = '0;
  logic [N-1:0] clk_req;
  logic [N-1:0] clk_ack;
  logic         all_idle;
`ifdef CLK_GATE_STATS_EN
  logic          stats_clr = 1'b0;
  logic [N*16-1:0] gated_cnt;
`endif

  clock_gate_ctrl #(
    .N        (N),
    .IDLE_CYC (IDLE_CYC),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .wake_req  (wake_req),
    .busy      (busy),
    .force_on  (force_on),
`ifdef CLK_GATE_STATS_EN
    .stats_clr (stats_clr),
    .gated_cnt (gated_cnt),
`endif
    .clk_req   (clk_req),
    .clk_ack   (clk_ack),
    .all_idle  (all_idle)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Per channel: is a clock requested, edges since the request rose, run of idle ON edges.
  bit req_m[N];
  int since_m[N];
  int idle_m[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      req_m[i] = 1'b0; since_m[i] = 0; idle_m[i] = 0;
    end
  endtask

  task automatic model_step();
    bit a;
    if (scan_en) return;
    for (int i = 0; i < N; i++) begin
      a = wake_req[i] | busy[i] | force_on[i];
      if (!req_m[i]) begin
        if (a) begin req_m[i] = 1'b1; since_m[i] = 0; idle_m[i] = 0; end
      end else if (since_m[i] < WAKE_CYC) begin
        since_m[i]++;
      end else if (a) begin
        idle_m[i] = 0;
      end else begin
        idle_m[i]++;
        if (idle_m[i] == IDLE_CYC) begin req_m[i] = 1'b0; idle_m[i] = 0; end
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0] r, k;
    logic idle;
    idle = 1'b1;
    for (int i = 0; i < N; i++) begin
      r[i] = req_m[i];
      k[i] = req_m[i] && (since_m[i] >= WAKE_CYC);
      if (req_m[i]) idle = 1'b0;
    end
    if (scan_en) begin r = '1; k = '1; end
    return {r, k, idle};
  endfunction

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scan_en = 1'b0;
    wake_req = '0; busy = '0; force_on = '0;
`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    @(negedge clk_in);
    @(negedge clk_in);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         scan;
    logic [N-1:0] wake;
    logic [N-1:0] bsy;
    logic [N-1:0] frc;
    logic [N-1:0] e_req;
    logic [N-1:0] e_ack;
    logic         e_idle;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int bad;
    logic [N-1:0] fv;

    tbl[0] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[1] = '{1'b0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b0};
    tbl[3] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 1'b0};
    tbl[4] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0};
    tbl[5] = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h6, 4'h2, 1'b0};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h2, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h6, 1'b0};

    // Reset values
    do_reset();
    #1;
    chk("rst_req", 32'(clk_req), 32'h0);
    chk("rst_ack", 32'(clk_ack), 32'h0);
    chk("rst_idle", 32'(all_idle), 32'h1);

    // Table: wake latency, scan freeze, second channel wake
    for (int t = 0; t < 8; t++) begin
      scan_en = tbl[t].scan; wake_req = tbl[t].wake;
      busy = tbl[t].bsy; force_on = tbl[t].frc;
      cycle();
      chk($sformatf("tbl%0d_req", t), 32'(clk_req), 32'(tbl[t].e_req));
      chk($sformatf("tbl%0d_ack", t), 32'(clk_ack), 32'(tbl[t].e_ack));
      chk($sformatf("tbl%0d_idle", t), 32'(all_idle), 32'(tbl[t].e_idle));
    end

    // Async reset while ch0 is ON
    do_reset();
    force_on = 4'h1;
    repeat (3) cycle();
    chk("on_before_rst", 32'(clk_ack[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(clk_req), 32'h0);
    chk("async_rst_ack", 32'(clk_ack), 32'h0);
    chk("async_rst_idle", 32'(all_idle), 32'h1);

    // Idle timeout on ch2, then re-entry and a late busy that restarts the window
    do_reset();
    busy = 4'h4;
    repeat (3) cycle();
    chk("ch2_on", 32'(clk_ack[2]), 32'h1);
    busy = 4'h0;
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      cycle();
      if (j < 15 && clk_req[2] !== 1'b1) bad++;
    end
    chk("idle_hold_m14", 32'(bad), 32'h0);
    chk("idle_off_m15", 32'(clk_req[2]), 32'h0);
    chk("idle_off_idle", 32'(all_idle), 32'h1);
    busy = 4'h4;
    cycle();
    chk("reentry_req", 32'(clk_req[2]), 32'h1);
    repeat (2) cycle();
    chk("reentry_ack", 32'(clk_ack[2]), 32'h1);
    busy = 4'h0;
    repeat (15) cycle();
    busy = 4'h4;
    cycle();
    chk("late_busy_stays_on", 32'(clk_req[2]), 32'h1);
    busy = 4'h0;
    repeat (15) cycle();
    chk("restart_window_on", 32'(clk_req[2]), 32'h1);
    cycle();
    chk("restart_window_off", 32'(clk_req[2]), 32'h0);

    // force_on holds ch3 for 100 cycles
    force_on = 4'h8;
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      cycle();
      if (j >= 2 && (clk_req[3] !== 1'b1 || clk_ack[3] !== 1'b1)) bad++;
    end
    chk("force_hold", 32'(bad), 32'h0);
    force_on = 4'h0;
    repeat (15) cycle();
    chk("force_rel_15", 32'(clk_req[3]), 32'h1);
    cycle();
    chk("force_rel_16", 32'(clk_req[3]), 32'h0);
    chk("force_rel_idle", 32'(all_idle), 32'h1);

    // Scan override with everything OFF
    scan_en = 1'b1;
    #1;
    chk("scan_req", 32'(clk_req), 32'hF);
    chk("scan_ack", 32'(clk_ack), 32'hF);
    wake_req = 4'hF;
    repeat (3) cycle();
    chk("scan_frozen_idle", 32'(all_idle), 32'h1);
    wake_req = 4'h0;
    scan_en = 1'b0;
    #1;
    chk("scan_off_req", 32'(clk_req), 32'h0);
    chk("scan_off_ack", 32'(clk_ack), 32'h0);

`ifdef CLK_GATE_STATS_EN
    do_reset();
    repeat (20) cycle();
    chk("stats_20", 32'(gated_cnt[15:0]), 32'd20);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    chk("stats_clr", 32'(gated_cnt[15:0]), 32'd0);
    repeat (65540) cycle();
    chk("stats_sat", 32'(gated_cnt[15:0]), 32'hFFFF);
`endif

    // Random stimulus against the model
    do_reset();
    fv = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        wake_req[i] = ($urandom_range(0, 39) == 0);
        busy[i]     = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 59) == 0) fv[i] = ~fv[i];
      end
      force_on = fv;
      scan_en  = ($urandom_range(0, 19) == 0);
      cycle();
      exp_q.push_back(model_out());
      chk($sformatf("rand%0d", c), 32'({clk_req, clk_ack, all_idle}), 32'(exp_q.pop_front()));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
